// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - reorder buffer with in-order retirement and free-list dealloc/restore
module rob_commit #(
  parameter int ROB_DEPTH     = 16,
  parameter int PHYS_REG_BITS = 7,
  parameter int ARCH_REG_BITS = 5,
  parameter int TAG_BITS      = $clog2(ROB_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic                     disp_has_dest,
  input  logic [ARCH_REG_BITS-1:0] disp_arch_rd,
  input  logic [PHYS_REG_BITS-1:0] disp_new_preg,
  input  logic [PHYS_REG_BITS-1:0] disp_old_preg,
  input  logic                     disp_is_branch,
  input  logic [PHYS_REG_BITS-1:0] disp_fl_ptr,
  output logic [TAG_BITS-1:0]      disp_tag,
  input  logic                     wb_valid,
  input  logic [TAG_BITS-1:0]      wb_tag,
  input  logic                     wb_mispredict,
  output logic                     commit_en,
  output logic [ARCH_REG_BITS-1:0] commit_arch_rd,
  output logic [PHYS_REG_BITS-1:0] commit_preg,
  output logic                     dealloc_en,
  output logic [PHYS_REG_BITS-1:0] dealloc_preg,
  output logic                     restore_en,
  output logic [PHYS_REG_BITS-1:0] restore_ptr,
  output logic                     flush,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = TAG_BITS + 1;

  // Pointers carry one extra MSB so full and empty can be told apart.
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_DEPTH-1:0] valid_q, valid_d, done_q, done_d, mispred_q, mispred_d;
  logic [ROB_DEPTH-1:0] has_dest_q, has_dest_d, is_branch_q, is_branch_d;
  logic [ARCH_REG_BITS-1:0] arch_rd_q  [ROB_DEPTH];
  logic [ARCH_REG_BITS-1:0] arch_rd_d  [ROB_DEPTH];
  logic [PHYS_REG_BITS-1:0] new_preg_q [ROB_DEPTH];
  logic [PHYS_REG_BITS-1:0] new_preg_d [ROB_DEPTH];
  logic [PHYS_REG_BITS-1:0] old_preg_q [ROB_DEPTH];
  logic [PHYS_REG_BITS-1:0] old_preg_d [ROB_DEPTH];
  logic [PHYS_REG_BITS-1:0] fl_ptr_q   [ROB_DEPTH];
  logic [PHYS_REG_BITS-1:0] fl_ptr_d   [ROB_DEPTH];

  logic [TAG_BITS-1:0] head_idx, tail_idx;
  logic                disp_fire;

  assign head_idx = head_q[TAG_BITS-1:0];
  assign tail_idx = tail_q[TAG_BITS-1:0];

  // Head-entry retirement, flush detection and dispatch handshake.
  always_comb begin
    empty          = (head_q == tail_q);
    full           = (head_idx == tail_idx) && (head_q[TAG_BITS] != tail_q[TAG_BITS]);
    commit_en      = !empty && valid_q[head_idx] && done_q[head_idx];
    flush          = commit_en && mispred_q[head_idx];
    disp_ready     = !full && !flush;
    disp_fire      = disp_valid && disp_ready;
    disp_tag       = tail_idx;
    dealloc_en     = commit_en && has_dest_q[head_idx];
    commit_arch_rd = '0;
    commit_preg    = '0;
    dealloc_preg   = '0;
    if (dealloc_en) begin
      commit_arch_rd = arch_rd_q[head_idx];
      commit_preg    = new_preg_q[head_idx];
      dealloc_preg   = old_preg_q[head_idx];
    end
    restore_en  = flush;
    restore_ptr = flush ? fl_ptr_q[head_idx] : '0;
  end

  // Next-state: writeback, retire, dispatch; a flush overrides pointers and valids.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    valid_d     = valid_q;
    done_d      = done_q;
    mispred_d   = mispred_q;
    has_dest_d  = has_dest_q;
    is_branch_d = is_branch_q;
    arch_rd_d   = arch_rd_q;
    new_preg_d  = new_preg_q;
    old_preg_d  = old_preg_q;
    fl_ptr_d    = fl_ptr_q;

    if (wb_valid && !flush && valid_q[wb_tag]) begin
      done_d[wb_tag]    = 1'b1;
      mispred_d[wb_tag] = wb_mispredict && is_branch_q[wb_tag];
    end

    if (commit_en) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + PW'(1);
    end

    if (disp_fire) begin
      valid_d[tail_idx]     = 1'b1;
      done_d[tail_idx]      = 1'b0;
      mispred_d[tail_idx]   = 1'b0;
      has_dest_d[tail_idx]  = disp_has_dest;
      is_branch_d[tail_idx] = disp_is_branch;
      arch_rd_d[tail_idx]   = disp_arch_rd;
      new_preg_d[tail_idx]  = disp_new_preg;
      old_preg_d[tail_idx]  = disp_old_preg;
      fl_ptr_d[tail_idx]    = disp_fl_ptr;
      tail_d                = tail_q + PW'(1);
    end

    if (flush) begin
      valid_d = '0;
      head_d  = head_q + PW'(1);
      tail_d  = head_q + PW'(1);
    end
  end

  // State register; reset discards every in-flight entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      done_q      <= '0;
      mispred_q   <= '0;
      has_dest_q  <= '0;
      is_branch_q <= '0;
      arch_rd_q   <= '{default: '0};
      new_preg_q  <= '{default: '0};
      old_preg_q  <= '{default: '0};
      fl_ptr_q    <= '{default: '0};
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      mispred_q   <= mispred_d;
      has_dest_q  <= has_dest_d;
      is_branch_q <= is_branch_d;
      arch_rd_q   <= arch_rd_d;
      new_preg_q  <= new_preg_d;
      old_preg_q  <= old_preg_d;
      fl_ptr_q    <= fl_ptr_d;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - scoreboard bench for rob_commit
module tb_rob_commit;
  localparam int D = 16, PB = 7, AB = 5, TB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, disp_valid, disp_ready, disp_has_dest, disp_is_branch;
  logic [AB-1:0] disp_arch_rd, commit_arch_rd;
  logic [PB-1:0] disp_new_preg, disp_old_preg, disp_fl_ptr;
  logic [TB-1:0] disp_tag, wb_tag;
  logic wb_valid, wb_mispredict, commit_en, dealloc_en, restore_en, flush, empty, full;
  logic [PB-1:0] commit_preg, dealloc_preg, restore_ptr;

  rob_commit #(.ROB_DEPTH(D), .PHYS_REG_BITS(PB), .ARCH_REG_BITS(AB), .TAG_BITS(TB)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_has_dest(disp_has_dest),
    .disp_arch_rd(disp_arch_rd), .disp_new_preg(disp_new_preg), .disp_old_preg(disp_old_preg),
    .disp_is_branch(disp_is_branch), .disp_fl_ptr(disp_fl_ptr), .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_mispredict(wb_mispredict),
    .commit_en(commit_en), .commit_arch_rd(commit_arch_rd), .commit_preg(commit_preg),
    .dealloc_en(dealloc_en), .dealloc_preg(dealloc_preg),
    .restore_en(restore_en), .restore_ptr(restore_ptr),
    .flush(flush), .empty(empty), .full(full)
  );

  typedef struct {
    logic [AB-1:0] arch;
    logic [PB-1:0] preg;
    logic          dl;
    logic [PB-1:0] dpreg;
    logic          fl;
    logic [PB-1:0] rptr;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 0; disp_has_dest = 0; disp_arch_rd = '0; disp_new_preg = '0;
    disp_old_preg = '0; disp_is_branch = 0; disp_fl_ptr = '0;
    wb_valid = 0; wb_tag = '0; wb_mispredict = 0;
  endtask

  task automatic do_reset();
    chk("sb_drained", 32'(sb.size()), 0);
    rst = 1; idle();
    tick(); tick();
    rst = 0;
  endtask

  // Dispatch one entry; the expected retirement is queued only if it should commit.
  task automatic disp(input logic hd, input int a, input int np, input int op, input logic br,
                      input int fp, input logic exp_commit, input logic exp_flush, input int exp_tag);
    exp_t e;
    disp_valid = 1; disp_has_dest = hd; disp_arch_rd = AB'(a); disp_new_preg = PB'(np);
    disp_old_preg = PB'(op); disp_is_branch = br; disp_fl_ptr = PB'(fp);
    #2;
    chk("disp_ready", 32'(disp_ready), 1);
    chk("disp_tag", 32'(disp_tag), 32'(exp_tag));
    if (exp_commit) begin
      e.arch  = hd ? AB'(a) : '0;
      e.preg  = hd ? PB'(np) : '0;
      e.dl    = hd;
      e.dpreg = hd ? PB'(op) : '0;
      e.fl    = exp_flush;
      e.rptr  = exp_flush ? PB'(fp) : '0;
      sb.push_back(e);
    end
    tick();
    disp_valid = 0;
  endtask

  // Monitor: every retirement must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (commit_en) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_commit: got commit_en 1 expected 0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("mon_arch_rd", 32'(commit_arch_rd), 32'(e.arch));
          chk("mon_preg", 32'(commit_preg), 32'(e.preg));
          chk("mon_dealloc_en", 32'(dealloc_en), 32'(e.dl));
          chk("mon_dealloc_preg", 32'(dealloc_preg), 32'(e.dpreg));
          chk("mon_flush", 32'({flush, restore_en}), e.fl ? 3 : 0);
          chk("mon_restore_ptr", 32'(restore_ptr), 32'(e.rptr));
        end
      end else begin
        chk("mon_idle_pulses", 32'({dealloc_en, flush, restore_en}), 0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; idle();
    tick(); tick();
    rst = 0;
    #2;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_disp_ready", 32'(disp_ready), 1);
    chk("rst_disp_tag", 32'(disp_tag), 0);
    chk("rst_pulses", 32'({commit_en, dealloc_en, restore_en, flush}), 0);
    chk("rst_data", 32'({commit_arch_rd, commit_preg, dealloc_preg, restore_ptr}), 0);
    tick();

    // Out-of-order completion, in-order retirement
    disp(1, 1, 10, 5, 0, 0, 1, 0, 0);
    disp(1, 2, 11, 6, 0, 0, 1, 0, 1);
    disp(1, 3, 12, 7, 0, 0, 1, 0, 2);
    wb_valid = 1; wb_tag = 2; wb_mispredict = 0;
    #2 chk("ooo_wait_tag2", 32'(commit_en), 0);
    tick();
    wb_tag = 0;
    #2 chk("ooo_no_bypass", 32'(commit_en), 0);
    tick();
    wb_tag = 1;
    #2 chk("ooo_commit0", 32'(commit_en), 1);
    chk("ooo_dealloc5", 32'(dealloc_preg), 5);
    tick();
    wb_valid = 0;
    #2 chk("ooo_commit1", 32'(commit_en), 1);
    chk("ooo_dealloc6", 32'(dealloc_preg), 6);
    tick();
    #2 chk("ooo_commit2", 32'(commit_en), 1);
    chk("ooo_dealloc7", 32'(dealloc_preg), 7);
    tick();
    #2 chk("ooo_empty", 32'(empty), 1);
    chk("ooo_idle", 32'(commit_en), 0);

    // Fill, wrap and conservative full
    do_reset();
    for (int i = 0; i < D; i++) disp(1, i, 20 + i, 40 + i, 0, 0, 1, 0, i);
    #2 chk("full_flag", 32'(full), 1);
    chk("full_not_ready", 32'(disp_ready), 0);
    chk("full_tag_held", 32'(disp_tag), 0);
    chk("full_not_empty", 32'(empty), 0);
    disp_valid = 1; disp_has_dest = 1; disp_arch_rd = 5'd31; disp_new_preg = 7'd1; disp_old_preg = 7'd2;
    wb_valid = 1; wb_tag = 0; wb_mispredict = 0;
    #0;
    tick();
    wb_valid = 0;
    #2 chk("full_commit", 32'(commit_en), 1);
    chk("full_no_credit", 32'(disp_ready), 0);
    tick();
    disp_valid = 0;
    #2 chk("full_after_commit", 32'(full), 0);
    chk("wrap_ready", 32'(disp_ready), 1);
    chk("wrap_tag", 32'(disp_tag), 0);
    disp(1, 17, 99, 77, 0, 0, 1, 0, 0);
    #2 chk("wrap_full_again", 32'(full), 1);
    for (int t = 1; t <= D; t++) begin
      wb_valid = 1; wb_tag = TB'(t % D);
      tick();
    end
    wb_valid = 0;
    for (int k = 0; k < 40 && !empty; k++) tick();
    #2 chk("drain_empty", 32'(empty), 1);

    // Mispredicted branch flushes younger entries
    do_reset();
    disp(1, 1, 60, 8, 0, 51, 1, 0, 0);
    disp(0, 0, 0, 0, 1, 40, 1, 1, 1);
    disp(1, 2, 61, 9, 0, 52, 0, 0, 2);
    disp(1, 3, 62, 10, 0, 53, 0, 0, 3);
    disp(1, 4, 63, 11, 0, 54, 0, 0, 4);
    wb_valid = 1; wb_tag = 1; wb_mispredict = 1;
    #2 chk("br_wait", 32'(commit_en), 0);
    tick();
    wb_tag = 0;
    #2 chk("br_no_bypass", 32'(commit_en), 0);
    tick();
    wb_tag = 2; wb_mispredict = 0;
    #2 chk("br_older_commit", 32'(commit_en), 1);
    chk("br_older_no_flush", 32'(flush), 0);
    chk("br_older_dealloc", 32'(dealloc_preg), 8);
    tick();
    wb_tag = 3; disp_valid = 1; disp_has_dest = 1; disp_arch_rd = 5'd7;
    #2 chk("br_commit", 32'(commit_en), 1);
    chk("br_flush", 32'({flush, restore_en}), 3);
    chk("br_restore_ptr", 32'(restore_ptr), 40);
    chk("br_disp_blocked", 32'(disp_ready), 0);
    chk("br_no_dest", 32'(dealloc_en), 0);
    tick();
    idle();
    #2 chk("post_flush_empty", 32'(empty), 1);
    chk("post_flush_tag", 32'(disp_tag), 2);
    for (int k = 0; k < 4; k++) tick();

    // No-dest retirement; reused slot must not inherit a stale done bit
    disp(0, 9, 70, 71, 0, 0, 1, 0, 2);
    disp(1, 6, 80, 81, 0, 0, 1, 0, 3);
    #2 chk("stale_done", 32'(commit_en), 0);
    wb_valid = 1; wb_tag = 2;
    tick();
    wb_tag = 3;
    #2 chk("nodest_commit", 32'(commit_en), 1);
    chk("nodest_dealloc_en", 32'(dealloc_en), 0);
    chk("nodest_data", 32'({commit_preg, dealloc_preg}), 0);
    tick();
    wb_valid = 0;
    for (int k = 0; k < 10 && !empty; k++) tick();
    #2 chk("final_empty", 32'(empty), 1);
    chk("sb_final", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer and in-order retirement engine; the deallocation side of the physical-register free list.
- Rename/dispatch writes one entry per cycle carrying the new and old physical mappings. Execution units mark entries complete.
- At the head, completed entries retire in order, driving the free list's dealloc port with the old mapping.
- A mispredicted branch at the head flushes all younger entries and drives the free list's restore port.

Parameters:
ROB_DEPTH, 16, number of entries (power of two, >=4)
PHYS_REG_BITS, 7, physical register index width (128 pregs)
ARCH_REG_BITS, 5, architectural register index width
TAG_BITS, $clog2(ROB_DEPTH), ROB tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
disp_valid  in  1  dispatch request
disp_ready  out  1  entry available and no flush this cycle
disp_has_dest  in  1  instruction writes a register
disp_arch_rd  in  ARCH_REG_BITS  destination architectural register
disp_new_preg  in  PHYS_REG_BITS  newly allocated preg
disp_old_preg  in  PHYS_REG_BITS  previous mapping of arch_rd
disp_is_branch  in  1  entry is a branch
disp_fl_ptr  in  PHYS_REG_BITS  free-list head value after this instruction's allocation
disp_tag  out  TAG_BITS  tag assigned to the dispatching entry (= tail index)
wb_valid  in  1  completion report
wb_tag  in  TAG_BITS  completing entry
wb_mispredict  in  1  branch resolved mispredicted (ignored if entry not branch)
commit_en  out  1  head entry retires this cycle
commit_arch_rd  out  ARCH_REG_BITS  retiring arch rd
commit_preg  out  PHYS_REG_BITS  retiring new preg (arch map update)
dealloc_en  out  1  free old preg
dealloc_preg  out  PHYS_REG_BITS  preg to free
restore_en  out  1  free-list restore pulse
restore_ptr  out  PHYS_REG_BITS  free-list head to restore
flush  out  1  pipeline flush pulse
empty  out  1  no valid entries
full  out  1  ROB_DEPTH valid entries

Behaviour:
- State:
  - head, tail pointers of TAG_BITS+1 bits; the extra MSB is for wrap detection.
  - Per entry: valid, done, mispred, has_dest, is_branch, arch_rd, new_preg, old_preg, fl_ptr.
- Flags:
  - empty = (head==tail).
  - full = (index bits equal) && (MSBs differ).
- Reset: head=tail=0, all valid/done cleared.
  - Outputs after reset: empty=1, full=0, disp_ready=1, disp_tag=0.
  - commit_en, dealloc_en, restore_en and flush are 0; all data outputs are 0.
- Dispatch (fire = disp_valid && disp_ready):
  - disp_ready = !full && !flush. Combinational; full is judged conservatively, with no same-cycle commit credit.
  - On fire, at the clock edge: write entry[tail], set valid=1, done=0, mispred=0; then tail++ (wraps modulo 2*ROB_DEPTH).
  - disp_tag = tail index, combinational.
- Writeback:
  - On wb_valid, if entry[wb_tag].valid: set done=1; set mispred = wb_mispredict && is_branch.
  - A writeback to an invalid entry is ignored.
  - A writeback to the head entry takes effect at the edge, so the earliest commit is the next cycle. There is no same-cycle bypass.
- Commit (combinational from head entry, zero latency):
  - commit_en = !empty && entry[head].valid && entry[head].done.
  - commit_arch_rd and commit_preg come from the head entry.
  - dealloc_en = commit_en && has_dest; dealloc_preg = old_preg. When dealloc_en=0, all commit data outputs are 0.
  - At the edge, clear entry[head].valid and head++.
  - Maximum one retirement per cycle.
- Flush:
  - Condition: commit_en && entry[head].mispred.
  - Same cycle: flush=1, restore_en=1, restore_ptr = entry[head].fl_ptr. The branch itself still commits, with its dealloc if it has a dest.
  - At the edge: head=tail=head+1; all valid bits cleared.
  - Dispatch is blocked that cycle (disp_ready=0). A wb_valid in the flush cycle is dropped.
  - Next cycle: empty=1.
- Simultaneous dispatch + commit, non-flush: both take effect; occupancy is unchanged.
- Wrap-around: the pointer MSB toggles on index wrap. Tags reuse the index bits only.
- Reset mid-operation: all in-flight entries are discarded. The free list is reset by the same rst, with no restore pulse.

Test Plan:
- Reset, then idle -> empty=1, full=0, disp_ready=1, all pulse outputs 0.
- Dispatch 3 entries (old_preg 5, 6, 7, has_dest=1), then wb tags 2, 0, 1 on consecutive cycles -> no commit until tag0 done. Then dealloc_preg 5, 6, 7 on 3 consecutive cycles, then empty=1.
- Dispatch 16 entries -> full=1, disp_ready=0, disp_tag held. Complete head and commit -> the following cycle disp_ready=1, disp_tag=0 (wrap), and the pointer MSB toggled.
- Branch at tag 1 (fl_ptr=40) plus 3 younger entries; wb tag1 mispredict, tag0 done -> tag0 commits. Next cycle: commit_en, flush, restore_en with restore_ptr=40. Following cycle: empty=1, and younger entries never commit.
- Entry with has_dest=0 done at head -> commit_en=1, dealloc_en=0.
- Full ROB, commit and dispatch attempted the same cycle -> dispatch refused, commit proceeds, and full=0 the next cycle.
